// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle load/store sequencer between MEM stage and word RAM
//
// Purpose: accepts one load/store request at a time, performs it against a word RAM
// that reads combinationally (word index = ram_addr[9:2]) and writes on the rising
// edge of ram_we, and returns a one-cycle response. Sub-word stores are done as
// read-modify-write; misaligned, out-of-range and size-3 requests are flagged.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready     request handshake; ready only while idle
//   req_write                 1 = store, 0 = load
//   req_size                  0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned              loads: 1 zero-extend, 0 sign-extend
//   req_addr, req_wdata       byte address, store data (low bits for sub-word)
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      load data (0 for stores/errors), error flag
//   ram_addr, ram_din, ram_we registered RAM address, write data, write strobe
//   ram_dout                  combinational RAM read data
module mem_access_unit #(
   parameter int MEM_WORDS = 256,
   parameter int WE_WIDTH  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   output logic        ram_we,
   input  logic [31:0] ram_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_SETUP,
      S_WE,
      S_HOLD,
      S_RESP
   } state_t;

   localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);
   localparam int          CW         = (WE_WIDTH > 1) ? $clog2(WE_WIDTH) : 1;
   localparam logic [CW-1:0] WE_LAST  = CW'(WE_WIDTH - 1);

   state_t        state;
   logic          wr_q;
   logic [1:0]    size_q;
   logic          uns_q;
   logic [1:0]    off_q;     // byte offset within the word; upper address bits live in ram_addr
   logic [15:0]   wdata_q;   // only the sub-word store lanes are needed after accept
   logic [CW-1:0] we_cnt;
   logic          req_bad;

   always_comb begin
      req_bad = 1'b0;
      if (req_size == 2'd3)                     req_bad = 1'b1;
      if (req_size == 2'd1 && req_addr[0])      req_bad = 1'b1;
      if (req_size == 2'd2 && |req_addr[1:0])   req_bad = 1'b1;
      if (req_addr >= ADDR_LIMIT)               req_bad = 1'b1;
   end

   // Little-endian lane select followed by sign/zero extension.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'd1:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed byte/half lane of the captured word with the store data.
   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic [15:0] wd);
      logic [31:0] r;
      r = word;
      if (size == 2'd0) begin
         case (off)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end else if (off[1]) begin
         r[31:16] = wd;
      end else begin
         r[15:0] = wd;
      end
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         ram_addr   <= 32'd0;
         ram_din    <= 32'd0;
         ram_we     <= 1'b0;
         wr_q       <= 1'b0;
         size_q     <= 2'd0;
         uns_q      <= 1'b0;
         off_q      <= 2'd0;
         wdata_q    <= 16'd0;
         we_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  wr_q      <= req_write;
                  size_q    <= req_size;
                  uns_q     <= req_unsigned;
                  off_q     <= req_addr[1:0];
                  wdata_q   <= req_wdata[15:0];
                  req_ready <= 1'b0;
                  if (req_bad) begin
                     // No RAM activity at all for rejected requests.
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                     state      <= S_RESP;
                  end else if (!req_write || req_size != 2'd2) begin
                     ram_addr <= {req_addr[31:2], 2'b00};
                     state    <= S_RD;
                  end else begin
                     ram_addr <= {req_addr[31:2], 2'b00};
                     ram_din  <= req_wdata;
                     state    <= S_SETUP;
                  end
               end
            end
            S_RD: begin
               if (!wr_q) begin
                  resp_rdata <= load_extract(ram_dout, size_q, off_q, uns_q);
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  ram_din <= store_merge(ram_dout, size_q, off_q, wdata_q);
                  state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               ram_we <= 1'b1;
               we_cnt <= WE_LAST;
               state  <= S_WE;
            end
            S_WE: begin
               if (we_cnt == '0) begin
                  ram_we <= 1'b0;
                  state  <= S_HOLD;
               end else begin
                  we_cnt <= we_cnt - 1'b1;
               end
            end
            S_HOLD: begin
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= 32'd0;
               state      <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
            default: begin
               ram_we     <= 1'b0;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard testbench for mem_access_unit
module tb_mem_access_unit;

   localparam int WE_WIDTH = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic        ram_we;
   logic [31:0] ram_dout;

   mem_access_unit #(.MEM_WORDS(256), .WE_WIDTH(WE_WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .ram_addr     (ram_addr),
      .ram_din      (ram_din),
      .ram_we       (ram_we),
      .ram_dout     (ram_dout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Word RAM: combinational read, write on rising edge of the strobe.
   logic [31:0] mem [256];
   int          we_total = 0;
   logic [31:0] rise_addr = 32'd0;
   logic [31:0] rise_din = 32'd0;
   assign ram_dout = mem[ram_addr[9:2]];
   always @(posedge ram_we) begin
      mem[ram_addr[9:2]] <= ram_din;
      we_total  <= we_total + 1;
      rise_addr <= ram_addr;
      rise_din  <= ram_din;
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
      int          pulses;
      logic [31:0] waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t        q[$];
   logic [31:0] ref_mem [256];
   int          n_pass = 0;
   int          n_total = 0;
   int          last_due = 0;
   int          we_base = 0;
   bit          stab_ok = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: computes the architectural outcome of one request and updates ref_mem.
   task automatic model(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, output exp_t e);
      logic [31:0] word, mask, val;
      int          nbytes, sh, idx;
      bit          bad;
      e.rdata = 32'd0; e.err = 1'b0; e.pulses = 0; e.waddr = 32'd0; e.wdata = 32'd0;
      bad = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a >= 1024);
      nbytes = 1 << sz;
      mask = (sz == 2) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 1);
      sh = 8 * int'(a % 4);
      if (bad) begin
         e.err = 1'b1;
         e.due = 1;
      end else begin
         idx = int'(a / 4);
         word = ref_mem[idx];
         if (!w) begin
            val = (word >> sh) & mask;
            if (!u && sz != 2 && val[8 * nbytes - 1]) val = val | ~mask;
            e.rdata = val;
            e.due = 2;
         end else begin
            word = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[idx] = word;
            e.pulses = 1;
            e.waddr = a - (a % 4);
            e.wdata = word;
            e.due = (sz == 2) ? 3 + WE_WIDTH : 4 + WE_WIDTH;
         end
      end
   endtask

   // Called just after a negedge; returns just after the negedge following the accept edge.
   task automatic issue(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input bit use_k = 1'b0, input logic [31:0] k = 32'd0);
      exp_t e;
      int   waited;
      bit   busy0;
      busy0 = !req_ready;
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      waited = 0;
      while (!req_ready) begin
         @(negedge clk);
         waited++;
         if (waited > 100) begin
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 100 cycles");
            $display("%0d/%0d checks passed", n_pass, n_total + 1);
            $fatal(1);
         end
      end
      model(w, sz, u, a, wd, e);
      if (use_k) e.rdata = k;
      e.due = e.due + cyc;
      if (busy0) chk("b2b_accept_cycle", 32'(cyc), 32'(last_due + 1));
      last_due = e.due;
      q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom_range(0, 1));
      req_size = 2'($urandom_range(0, 3));
      req_addr = $urandom;
      req_wdata = $urandom;
   endtask

   initial begin
      logic [1:0]  rsz;
      logic [31:0] ra;
      bit          seen;

      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (rst) begin
               q.delete();
               we_base = we_total;
               stab_ok = 1'b1;
            end else begin
               if (we_total != we_base && (ram_addr !== rise_addr || ram_din !== rise_din))
                  stab_ok = 1'b0;
               if (resp_valid) begin
                  if (q.size() == 0) begin
                     n_total++;
                     $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
                  end else begin
                     e = q.pop_front();
                     chk("resp_rdata", resp_rdata, e.rdata);
                     chk("resp_err", 32'(resp_err), 32'(e.err));
                     chk("latency_cycle", 32'(cyc), 32'(e.due));
                     chk("we_pulses", 32'(we_total - we_base), 32'(e.pulses));
                     chk("ready_in_resp", 32'(req_ready), 32'd0);
                     if (e.pulses > 0) begin
                        chk("write_addr", rise_addr, e.waddr);
                        chk("write_data", rise_din, e.wdata);
                        chk("addr_din_stable", 32'(stab_ok), 32'd1);
                     end
                  end
                  we_base = we_total;
                  stab_ok = 1'b1;
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_din", ram_din, 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Fill the whole RAM with back-to-back word stores
      for (int i = 0; i < 256; i++) issue(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);

      // Directed cases with fixed expected values
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8844_22F1);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h8844_22F1);
      issue(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, 1'b1, 32'hFFFF_FFF1);
      issue(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, 1'b1, 32'h0000_00F1);
      issue(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 1'b1, 32'hFFFF_8844);
      issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 1'b1, 32'h0000_8844);
      issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h8844_ABF1);
      issue(1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_1234);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h1234_ABF1);
      issue(1'b0, 2'd2, 1'b0, 32'h13, 32'd0);
      issue(1'b0, 2'd1, 1'b0, 32'h11, 32'd0);
      issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0);
      issue(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
      issue(1'b1, 2'd2, 1'b0, 32'h3FF, 32'h1111_1111);
      issue(1'b1, 2'd0, 1'b0, 32'h400, 32'h2222_2222);
      issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEAD_BEEF);
      issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1, 32'hDEAD_BEEF);

      // Randomized mix, with occasional idle gaps
      for (int i = 0; i < 300; i++) begin
         rsz = 2'($urandom_range(0, 3));
         ra = 32'($urandom_range(0, 1099));
         if (rsz != 2'd3 && $urandom_range(0, 3) != 0) ra = ra - (ra % (32'd1 << rsz));
         issue(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra, $urandom);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      end

      // Asynchronous reset while the strobe is high
      issue(1'b1, 2'd2, 1'b0, 32'h24, 32'h5555_AAAA);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (ram_we) seen = 1'b1;
      end
      chk("we_seen_before_reset", 32'(seen), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ram_we", 32'(ram_we), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      issue(1'b0, 2'd2, 1'b0, 32'h24, 32'd0, 1'b1, 32'h5555_AAAA);
      issue(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, 1'b1, 32'h0000_00AB);

      for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
